// File: rtl/memory_stage.sv
// Y86-64 pipeline memory stage: byte-addressed data memory plus the W pipeline register.
// Reads are combinational for forwarding; writes commit on the rising edge.
module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] m_valM,
    output logic [1:0]  m_stat,
    output logic [1:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic        W_cnd,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int          NUM_LANES = 8;
    localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] MAX_ADDR  = 64'(MEM_BYTES - NUM_LANES);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_ADR = 2'd2;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: 64'd0,
        val_m: 64'd0,
        dst_e: R_NONE,
        dst_m: R_NONE
    };

    // Zero at time 0 only; reset deliberately leaves contents alone.
    logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

    logic                             mem_read, mem_write, mem_error;
    logic [63:0]                      mem_addr;
    logic [AW-1:0]                    base_idx;
    logic [NUM_LANES-1:0][AW-1:0]     lane_idx;
    logic [NUM_LANES-1:0][7:0]        rd_bytes;
    logic                             wr_en;
    w_reg_t                           w_q, w_d;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = M_valE;
        unique case (M_icode)
            I_MRMOVQ:        mem_read  = 1'b1;
            I_RET, I_POPQ: begin
                mem_read = 1'b1;
                mem_addr = M_valA;
            end
            I_RMMOVQ, I_CALL, I_PUSHQ: mem_write = 1'b1;
            default: ;
        endcase
    end

    // Full 64-bit compare so a huge address can never alias into the array.
    assign mem_error = (mem_read || mem_write) && (mem_addr > MAX_ADDR);
    assign base_idx  = mem_addr[AW-1:0];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_idx[i] = base_idx + AW'(i);
        assign rd_bytes[i] = mem[lane_idx[i]];
    end

    assign m_valM = (mem_read && !mem_error) ? rd_bytes : 64'd0;
    assign m_stat = mem_error ? STAT_ADR : M_stat;

    // No commit once anything upstream or in W has faulted.
    assign wr_en = !reset && mem_write && !mem_error &&
                   (M_stat == STAT_AOK) && (w_q.stat == STAT_AOK);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++)
                mem[lane_idx[i]] <= M_valA[8*i +: 8];
        end
    end

    always_comb begin
        w_d = w_q;
        if (W_bubble) begin
            w_d = W_BUBBLE;
        end else if (!W_stall) begin
            w_d.stat  = m_stat;
            w_d.icode = M_icode;
            w_d.cnd   = M_cnd;
            w_d.val_e = M_valE;
            w_d.val_m = m_valM;
            w_d.dst_e = M_dstE;
            w_d.dst_m = M_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) w_q <= W_BUBBLE;
        else       w_q <= w_d;
    end

    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign W_cnd   = w_q.cnd;
    assign W_valE  = w_q.val_e;
    assign W_valM  = w_q.val_m;
    assign W_dstE  = w_q.dst_e;
    assign W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change 1ns after a rising edge,
// outputs are checked mid-cycle against hand-computed values.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA, M_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic        W_stall, W_bubble;
    logic [63:0] m_valM;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic        W_cnd;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;

    int errors = 0;
    int checks = 0;

    memory_stage #(.MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valA(M_valA), .M_valE(M_valE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_cnd(W_cnd),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] st, input logic [3:0] ic,
                         input logic [63:0] va, input logic [63:0] ve,
                         input logic [3:0] de, input logic [3:0] dm);
        M_stat = st; M_icode = ic; M_valA = va; M_valE = ve;
        M_dstE = de; M_dstM = dm;
        #1;
    endtask

    initial begin
        reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; M_cnd = 1'b1;
        drive(2'd0, 4'h4, 64'hDEAD_BEEF, 64'h30, 4'h2, 4'hF);
        tick();
        tick();
        chk("rst_icode", 64'(W_icode), 64'h1);
        chk("rst_stat",  64'(W_stat),  64'h0);
        chk("rst_cnd",   64'(W_cnd),   64'h0);
        chk("rst_dstE",  64'(W_dstE),  64'hF);
        chk("rst_dstM",  64'(W_dstM),  64'hF);
        chk("rst_valE",  W_valE,       64'h0);
        chk("rst_valM",  W_valM,       64'h0);

        reset = 1'b0;
        drive(2'd0, 4'h4, 64'h1122334455667788, 64'h10, 4'hF, 4'hF);
        chk("wr_no_valM", m_valM, 64'h0);
        chk("wr_mstat",   64'(m_stat), 64'h0);
        tick();
        chk("wr_W_icode", 64'(W_icode), 64'h4);
        chk("wr_W_valE",  W_valE, 64'h10);
        chk("wr_W_cnd",   64'(W_cnd), 64'h1);

        drive(2'd0, 4'h5, 64'h0, 64'h10, 4'hF, 4'h3);
        chk("rd10_comb", m_valM, 64'h1122334455667788);
        chk("rd10_lowbyte", 64'(m_valM[7:0]), 64'h88);
        tick();
        chk("rd10_W_valM", W_valM, 64'h1122334455667788);
        chk("rd10_W_dstM", 64'(W_dstM), 64'h3);

        drive(2'd0, 4'h5, 64'h0, 64'h11, 4'hF, 4'h3);
        chk("rd11_unaligned", m_valM, 64'h0011223344556677);
        drive(2'd0, 4'h5, 64'h0, 64'h30, 4'hF, 4'h3);
        chk("rd30_reset_blocked", m_valM, 64'h0);

        drive(2'd0, 4'h5, 64'h0, 64'h3FC, 4'hF, 4'h3);
        chk("err_valM", m_valM, 64'h0);
        chk("err_mstat", 64'(m_stat), 64'h2);
        tick();
        chk("err_W_stat", 64'(W_stat), 64'h2);
        chk("err_W_valM", W_valM, 64'h0);

        drive(2'd0, 4'h5, 64'h0, 64'h3F8, 4'hF, 4'h3);
        chk("lastok_mstat", 64'(m_stat), 64'h0);
        drive(2'd1, 4'h5, 64'h0, 64'h3F8, 4'hF, 4'h3);
        chk("lastok_pass_stat", 64'(m_stat), 64'h1);
        drive(2'd0, 4'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 4'hF, 4'h3);
        chk("huge_addr_err", 64'(m_stat), 64'h2);
        drive(2'd0, 4'h9, 64'h400, 64'h0, 4'hF, 4'hF);
        chk("ret_valA_err", 64'(m_stat), 64'h2);
        drive(2'd0, 4'h6, 64'h0, 64'hFFFF_0000, 4'h1, 4'hF);
        chk("noacc_no_err", 64'(m_stat), 64'h0);

        // W holds ADR here, so this store must be dropped.
        drive(2'd0, 4'h4, 64'hFF, 64'h20, 4'hF, 4'hF);
        tick();
        chk("W_stat_cleared", 64'(W_stat), 64'h0);
        drive(2'd0, 4'h5, 64'h0, 64'h20, 4'hF, 4'h3);
        chk("wr_blocked_Wstat", m_valM, 64'h0);

        drive(2'd1, 4'h4, 64'h55, 64'h40, 4'hF, 4'hF);
        tick();
        chk("hlt_W_stat", 64'(W_stat), 64'h1);
        drive(2'd0, 4'h5, 64'h0, 64'h40, 4'hF, 4'h3);
        chk("wr_blocked_Mstat", m_valM, 64'h0);
        tick();

        drive(2'd0, 4'hB, 64'h10, 64'h18, 4'h4, 4'h5);
        chk("popq_uses_valA", m_valM, 64'h1122334455667788);
        tick();
        drive(2'd0, 4'hA, 64'hCAFE_F00D_1234_5678, 64'h08, 4'h4, 4'hF);
        tick();
        drive(2'd0, 4'h5, 64'h0, 64'h08, 4'hF, 4'h3);
        chk("pushq_stored", m_valM, 64'hCAFE_F00D_1234_5678);
        drive(2'd0, 4'h5, 64'h0, 64'h10, 4'hF, 4'h3);
        chk("pushq_neighbor", m_valM, 64'h1122334455667788);
        drive(2'd0, 4'h5, 64'h0, 64'h08, 4'hF, 4'h3);
        tick();

        W_stall = 1'b1;
        drive(2'd0, 4'h4, 64'h77, 64'h50, 4'h2, 4'hF);
        tick();
        chk("stall_icode", 64'(W_icode), 64'h5);
        chk("stall_valE",  W_valE, 64'h08);
        chk("stall_valM",  W_valM, 64'hCAFE_F00D_1234_5678);
        chk("stall_dstM",  64'(W_dstM), 64'h3);
        W_stall = 1'b0;
        drive(2'd0, 4'h5, 64'h0, 64'h50, 4'hF, 4'h3);
        chk("stall_write_done", m_valM, 64'h77);

        W_stall = 1'b1; W_bubble = 1'b1;
        drive(2'd0, 4'h5, 64'h0, 64'h50, 4'h2, 4'h3);
        tick();
        chk("bubble_icode", 64'(W_icode), 64'h1);
        chk("bubble_dstE",  64'(W_dstE), 64'hF);
        chk("bubble_dstM",  64'(W_dstM), 64'hF);
        chk("bubble_valM",  W_valM, 64'h0);
        chk("bubble_cnd",   64'(W_cnd), 64'h0);
        W_stall = 1'b0; W_bubble = 1'b0;

        // A store presented with reset asserted must not land.
        reset = 1'b1;
        drive(2'd0, 4'h8, 64'h99, 64'h60, 4'h4, 4'hF);
        tick();
        reset = 1'b0;
        chk("rst_over_normal", 64'(W_icode), 64'h1);
        drive(2'd0, 4'h5, 64'h0, 64'h60, 4'hF, 4'h3);
        chk("rst_blocks_call", m_valM, 64'h0);
        drive(2'd0, 4'h5, 64'h0, 64'h10, 4'hF, 4'h3);
        chk("rst_keeps_mem", m_valM, 64'h1122334455667788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
